seg_mux_receiver: RTL and testbench
===================================

SEG_MUX_RECEIVER -- requirements
Module: seg_mux_receiver

Interface
REQ-001 Parameter STABLE_FRAMES, default 2, meaning the number of consecutive identical complete frames required before a value is committed (legal range 1..15).
REQ-002 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1, the asynchronous, active-low reset.
REQ-004 Ports a, b, c, d, e, f, g, input, 1 each, active-low segment lines; the vector {a,b,c,d,e,f,g} has a as MSB.
REQ-005 Port dp, input, 1, the decimal point line; ignored.
REQ-006 Ports dig1, dig2, input, 1 each, the digit strobes; {dig1,dig2}=10 is the tens phase, 01 the ones phase, 00 idle, 11 illegal.
REQ-007 Port tens, output, 4, the committed tens digit.
REQ-008 Port ones, output, 4, the committed ones digit.
REQ-009 Port value, output, 7, the committed binary value tens*10+ones, 0..99.
REQ-010 Port valid, output, 1, a one-cycle pulse marking a newly committed value.
REQ-011 Port locked, output, 1, high once any value has been committed.
REQ-012 Port err, output, 1, a one-cycle pulse per detected protocol or pattern error.
REQ-013 Port err_count, output, 8, the saturating error counter.

Function
REQ-014 All pin inputs shall be registered once (input stage) before any use.
REQ-015 Segment decode shall map 7'h01->0, 4F->1, 12->2, 06->3, 4C->4, 24->5, 60->6, 0F->7, 00->8, 0C->9; every other pattern is invalid.
REQ-016 In the tens phase, pattern 7'h7F (blank) shall decode as digit 0; in the ones phase, 7'h7F is invalid.
REQ-017 Phase FSM states: HUNT (no tens held), GOT_TENS (tens digit held); reset state HUNT.
REQ-018 HUNT + valid tens sample -> GOT_TENS, store digit; HUNT + ones or idle sample -> stay, no error.
REQ-019 GOT_TENS + valid tens sample -> stay and overwrite stored tens; GOT_TENS + valid ones sample -> complete frame, go to HUNT.
REQ-020 GOT_TENS + idle sample -> stay (holding is permitted across idle cycles).
REQ-021 An invalid pattern in either phase, or strobe 11, shall pulse err, increment err_count (saturating at 255), discard any partial frame, and go to HUNT.
REQ-022 On frame completion: if the frame equals the previous frame, match_cnt increments, saturating at STABLE_FRAMES-1; otherwise the frame is stored as previous and match_cnt is cleared to 0.
REQ-023 When match_cnt equals STABLE_FRAMES-1 after this update and (locked=0 or the frame differs from the committed tens/ones), tens/ones/value shall update and valid shall pulse.
REQ-024 A re-confirmed frame equal to the committed value shall produce no valid pulse.
REQ-025 Latency: valid is high in the second cycle after the clock edge that samples the completing ones strobe at the pins (input-stage edge, then commit edge).
REQ-026 value shall be computed combinationally from tens and ones as tens*10+ones with 7-bit result width; it never exceeds 99.
REQ-027 Outputs tens, ones, value, and locked shall hold between commits.

Reset
REQ-028 On rst_n low, regardless of clk: tens=0, ones=0, value=0, valid=0, locked=0, err=0, err_count=0, FSM=HUNT, match_cnt=0, previous-frame register cleared, input stage cleared to idle.
REQ-029 Reset asserted mid-frame shall discard the partial frame; the first frame after reset release starts from HUNT.

Structure
REQ-030 Package segrx_pkg shall hold the ten segment constants, the blank constant, and the phase/FSM state enumerations.
REQ-031 One combinational sub-module seg_to_bcd (7-bit pattern plus is_tens -> 4-bit digit plus ok flag) shall be instantiated once and shared by both phases.

Verification
REQ-032 Alternate strobes 10/7'h12 then 01/7'h06 for 3 frames -> single valid pulse; tens=2, ones=3, value=23, locked=1.
REQ-033 Frames 45, 46, 46 with STABLE_FRAMES=2 -> one valid pulse after the third frame; value=46, with no commit of 45.
REQ-034 Ones phase carries 7'h7E -> err pulses once, err_count=1, frame discarded, committed value unchanged.
REQ-035 Strobe 11 for 300 cycles -> err_count saturates at 255, and no valid pulse occurs.
REQ-036 Tens phase blank 7'h7F, ones phase 7'h0F, repeated -> value=7; then rst_n pulsed low mid-frame -> all outputs 0 immediately, and locked=0.
REQ-037 Stream starting with a ones phase, then a tens phase repeated twice with 7'h4C then 7'h24, then a ones phase with 7'h00 -> leading ones ignored, and the committed value is 58.

Source files
------------

// File: rtl/segrx_pkg.sv
// segrx_pkg: segment patterns and state types shared by the seven-segment receiver
package segrx_pkg;
  localparam logic [6:0] SEG_0     = 7'h01;
  localparam logic [6:0] SEG_1     = 7'h4F;
  localparam logic [6:0] SEG_2     = 7'h12;
  localparam logic [6:0] SEG_3     = 7'h06;
  localparam logic [6:0] SEG_4     = 7'h4C;
  localparam logic [6:0] SEG_5     = 7'h24;
  localparam logic [6:0] SEG_6     = 7'h60;
  localparam logic [6:0] SEG_7     = 7'h0F;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h0C;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  typedef enum logic [1:0] {PH_IDLE = 2'b00, PH_ONES = 2'b01, PH_TENS = 2'b10, PH_ILL = 2'b11} phase_e;
  typedef enum logic {HUNT = 1'b0, GOT_TENS = 1'b1} state_e;
endpackage

// File: rtl/seg_to_bcd.sv
// seg_to_bcd: active-low segment pattern to decimal digit; blank reads as 0 only for tens
module seg_to_bcd
  import segrx_pkg::*;
(
  input  logic [6:0] pat_i,
  input  logic       is_tens_i,
  output logic [3:0] digit_o,
  output logic       ok_o
);
  // pattern lookup; anything unlisted is flagged not ok
  always_comb begin
    digit_o = 4'd0;
    ok_o = 1'b1;
    case (pat_i)
      SEG_0:     digit_o = 4'd0;
      SEG_1:     digit_o = 4'd1;
      SEG_2:     digit_o = 4'd2;
      SEG_3:     digit_o = 4'd3;
      SEG_4:     digit_o = 4'd4;
      SEG_5:     digit_o = 4'd5;
      SEG_6:     digit_o = 4'd6;
      SEG_7:     digit_o = 4'd7;
      SEG_8:     digit_o = 4'd8;
      SEG_9:     digit_o = 4'd9;
      SEG_BLANK: ok_o = is_tens_i;
      default:   ok_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/seg_mux_receiver.sv
// seg_mux_receiver: decodes a two-digit multiplexed seven-segment display into a debounced value
module seg_mux_receiver
  import segrx_pkg::*;
#(
  parameter int unsigned STABLE_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  input  logic       dp,
  input  logic       dig1,
  input  logic       dig2,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [6:0] value,
  output logic       valid,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_count
);
  localparam logic [3:0] MATCH_MAX = 4'(STABLE_FRAMES - 1);
  logic [6:0] seg_q;
  phase_e     ph_q;
  state_e     state_q, state_d;
  logic [3:0] hold_q, hold_d, prev_t_q, prev_o_q, match_q, match_d, tens_q, ones_q;
  logic       prev_v_q, locked_q, valid_q, err_q;
  logic [7:0] err_cnt_q;
  logic [3:0] digit;
  logic       ok, err_ev, done, same, commit, unused_dp;
  assign unused_dp = dp;
  // input stage: every pin is registered once before decode
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      seg_q <= SEG_BLANK;
      ph_q  <= PH_IDLE;
    end else begin
      seg_q <= {a, b, c, d, e, f, g};
      ph_q  <= phase_e'({dig1, dig2});
    end
  seg_to_bcd u_dec (.pat_i(seg_q), .is_tens_i(ph_q == PH_TENS), .digit_o(digit), .ok_o(ok));
  assign err_ev  = (ph_q == PH_ILL) || ((ph_q == PH_TENS || ph_q == PH_ONES) && !ok);
  assign done    = state_q == GOT_TENS && ph_q == PH_ONES && ok;
  assign same    = prev_v_q && hold_q == prev_t_q && digit == prev_o_q;
  assign match_d = !done ? match_q : !same ? 4'd0 : match_q == MATCH_MAX ? match_q : match_q + 4'd1;
  assign commit  = done && match_d == MATCH_MAX && (!locked_q || hold_q != tens_q || digit != ones_q);
  // phase FSM: a tens digit is held until its ones digit arrives; errors drop the partial frame
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (err_ev) state_d = HUNT;
    else if (ph_q == PH_TENS) begin
      state_d = GOT_TENS;
      hold_d  = digit;
    end else if (done) state_d = HUNT;
  end
  // frame history, commit registers and error counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= HUNT;
      hold_q    <= 4'd0;
      prev_t_q  <= 4'd0;
      prev_o_q  <= 4'd0;
      prev_v_q  <= 1'b0;
      match_q   <= 4'd0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      locked_q  <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      match_q <= match_d;
      if (done && !same) begin
        prev_t_q <= hold_q;
        prev_o_q <= digit;
        prev_v_q <= 1'b1;
      end
      if (commit) begin
        tens_q   <= hold_q;
        ones_q   <= digit;
        locked_q <= 1'b1;
      end
      valid_q <= commit;
      err_q   <= err_ev;
      if (err_ev && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  assign tens      = tens_q;
  assign ones      = ones_q;
  assign value     = 7'(tens_q) * 7'd10 + 7'(ones_q);
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign err       = err_q;
  assign err_count = err_cnt_q;
endmodule

// File: tb/tb_seg_mux_receiver.sv
// tb_seg_mux_receiver: directed frames with a commit scoreboard checked by a valid-driven monitor
module tb_seg_mux_receiver;
  logic clk = 1'b0, rst_n = 1'b0;
  logic a, b, c, d, e, f, g, dp, dig1, dig2;
  logic [3:0] tens, ones;
  logic [6:0] value;
  logic valid, locked, err;
  logic [7:0] err_count;
  int tests = 0, fails = 0, err_seen = 0, e0;
  logic [14:0] exp_q[$];
  seg_mux_receiver #(.STABLE_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp),
    .dig1(dig1), .dig2(dig2), .tens(tens), .ones(ones), .value(value), .valid(valid),
    .locked(locked), .err(err), .err_count(err_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic push(input int t, input int o, input int v);
    exp_q.push_back({4'(t), 4'(o), 7'(v)});
  endtask
  always @(negedge clk) begin
    logic [14:0] x;
    if (rst_n && err) err_seen++;
    if (rst_n && valid) begin
      if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        x = exp_q.pop_front();
        check("commit_tens", int'(tens), int'(x[14:11]));
        check("commit_ones", int'(ones), int'(x[10:7]));
        check("commit_value", int'(value), int'(x[6:0]));
      end
    end
  end
  task automatic send(input logic [1:0] dg, input logic [6:0] s);
    @(negedge clk);
    {dig1, dig2} = dg;
    {a, b, c, d, e, f, g} = s;
    dp = 1'($urandom_range(0, 1));
  endtask
  task automatic idle(input int n);
    repeat (n) send(2'b00, 7'h7F);
  endtask
  task automatic frame(input logic [6:0] t, input logic [6:0] o);
    send(2'b10, t);
    send(2'b01, o);
    send(2'b00, 7'h7F);
  endtask
  task automatic check_zero(input string nm);
    check({nm, "_tens"}, int'(tens), 0);
    check({nm, "_ones"}, int'(ones), 0);
    check({nm, "_value"}, int'(value), 0);
    check({nm, "_valid"}, int'(valid), 0);
    check({nm, "_locked"}, int'(locked), 0);
    check({nm, "_err"}, int'(err), 0);
    check({nm, "_err_count"}, int'(err_count), 0);
  endtask
  initial begin
    {a, b, c, d, e, f, g} = 7'h7F;
    {dig1, dig2, dp} = 3'b000;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    idle(2);
    // 23 three times: commit after the second, latency of two edges, no repeat pulse
    push(2, 3, 23);
    frame(7'h12, 7'h06);
    send(2'b10, 7'h12);
    send(2'b01, 7'h06);
    @(negedge clk);
    check("latency_early", int'(valid), 0);
    @(negedge clk);
    check("latency_on_time", int'(valid), 1);
    idle(2);
    frame(7'h12, 7'h06);
    idle(3);
    check("t1_value", int'(value), 23);
    check("t1_locked", int'(locked), 1);
    // 45, 46, 46 (idle held inside the last frame): only 46 commits
    push(4, 6, 46);
    frame(7'h4C, 7'h24);
    frame(7'h4C, 7'h60);
    send(2'b10, 7'h4C);
    idle(2);
    send(2'b01, 7'h60);
    idle(4);
    check("t2_value", int'(value), 46);
    // invalid ones pattern
    e0 = err_seen;
    frame(7'h4C, 7'h7E);
    idle(3);
    check("t3_err_pulses", err_seen - e0, 1);
    check("t3_err_count", int'(err_count), 1);
    check("t3_value_kept", int'(value), 46);
    // illegal strobe for 300 cycles saturates the counter
    e0 = err_seen;
    repeat (300) send(2'b11, 7'h12);
    idle(3);
    check("t4_err_pulses", err_seen - e0, 300);
    check("t4_err_count_sat", int'(err_count), 255);
    check("t4_value_kept", int'(value), 46);
    // blank tens reads as zero
    push(0, 7, 7);
    frame(7'h7F, 7'h0F);
    frame(7'h7F, 7'h0F);
    idle(3);
    check("t5_value", int'(value), 7);
    // asynchronous reset mid-frame
    send(2'b10, 7'h12);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    // leading ones ignored, tens overwritten, 58 committed on second frame
    repeat (2) begin
      send(2'b01, 7'h06);
      send(2'b10, 7'h4C);
      send(2'b10, 7'h24);
      send(2'b01, 7'h00);
      idle(1);
      if (exp_q.size() == 0 && !locked) push(5, 8, 58);
    end
    idle(4);
    check("t6_value", int'(value), 58);
    check("t6_locked", int'(locked), 1);
    check("t6_err_count", int'(err_count), 0);
    check("pending_commits", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
